// File: rtl/hopf_pkg.sv
// rtl/hopf_pkg.sv - shared constants and FSM encoding for the Hopf noise source
package hopf_pkg;
  localparam logic [31:0] LFSR_MASK    = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE12468;
  localparam int          Q_FRAC       = 14;
  localparam int          ONE          = 1 << Q_FRAC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2
  } state_t;
endpackage

// File: rtl/hopf_noise_source_if.sv
// rtl/hopf_noise_source_if.sv - request/seed/gain inputs and noise outputs of the noise source
interface hopf_noise_source_if #(
  parameter int WIDTH = 18
);
  logic                    clk_en;
  logic                    seed_load;
  logic [31:0]             seed_in;
  logic signed [WIDTH-1:0] noise_gain;
  logic signed [WIDTH-1:0] noise_x;
  logic                    noise_valid;
  logic                    busy;

  modport master (
    output clk_en, seed_load, seed_in, noise_gain,
    input  noise_x, noise_valid, busy
  );

  modport slave (
    input  clk_en, seed_load, seed_in, noise_gain,
    output noise_x, noise_valid, busy
  );
endinterface

// File: rtl/noise_lfsr32.sv
// rtl/noise_lfsr32.sv - 32-bit Galois right-shift LFSR with step enable and zero-seed guard
module noise_lfsr32
  import hopf_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] state,
  output logic [31:0] next_state
);
  logic [31:0] q;

  assign next_state = (q >> 1) ^ (q[0] ? LFSR_MASK : 32'h0);
  assign state      = q;

  // A zero seed would lock the register up, so it falls back to SEED.
  always_ff @(posedge clk) begin
    if (rst)       q <= SEED;
    else if (load) q <= (load_value == 32'h0) ? SEED : load_value;
    else if (step) q <= next_state;
  end
endmodule

// File: rtl/hopf_noise_source.sv
// rtl/hopf_noise_source.sv - Irwin-Hall Gaussian noise generator feeding the stochastic Hopf oscillator
module hopf_noise_source
  import hopf_pkg::*;
#(
  parameter int          WIDTH = 18,
  parameter int          FRAC  = 14,
  parameter int          SUM_N = 4,
  parameter logic [31:0] SEED  = DEFAULT_SEED
) (
  input logic               clk,
  input logic               rst,
  hopf_noise_source_if.slave bus
);
  localparam int CNT_W = (SUM_N > 1) ? $clog2(SUM_N) : 1;
  localparam int ACC_W = 12 + CNT_W;
  localparam int PW    = ACC_W + 1 + WIDTH;
  localparam logic [CNT_W-1:0]     LAST   = CNT_W'(SUM_N - 1);
  localparam logic signed [ACC_W:0] CENTER = (ACC_W + 1)'(SUM_N * 2048);
  localparam logic signed [PW-1:0] P_MAX  = PW'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] P_MIN  = -P_MAX - PW'(1);

  state_t                  state_q, state_d;
  logic [ACC_W-1:0]        acc;
  logic [CNT_W-1:0]        count;
  logic signed [WIDTH-1:0] noise_q, noise_sat;
  logic                    valid_q;
  logic                    lfsr_step, sample_done;
  logic [31:0]             lfsr_state, lfsr_next;
  logic signed [ACC_W:0]   centred;
  logic signed [PW-1:0]    centred_ext, gain_ext, prod, shifted;

  noise_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .step      (lfsr_step),
    .load      (bus.seed_load),
    .load_value(bus.seed_in),
    .state     (lfsr_state),
    .next_state(lfsr_next)
  );

  always_comb begin
    state_d     = state_q;
    lfsr_step   = 1'b0;
    sample_done = 1'b0;
    if (bus.seed_load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (bus.clk_en) state_d = ACCUM;
        ACCUM: begin
          lfsr_step = 1'b1;
          if (count == LAST) state_d = SCALE;
        end
        SCALE: begin
          sample_done = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Full-precision product; only the shifted result is narrowed, with clamping.
  always_comb begin
    centred     = $signed({1'b0, acc}) - CENTER;
    centred_ext = centred;
    gain_ext    = bus.noise_gain;
    prod        = centred_ext * gain_ext;
    shifted     = prod >>> FRAC;
    if (shifted > P_MAX)      noise_sat = P_MAX[WIDTH-1:0];
    else if (shifted < P_MIN) noise_sat = P_MIN[WIDTH-1:0];
    else                      noise_sat = shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc     <= '0;
      count   <= '0;
      noise_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= sample_done;
      if (bus.seed_load || state_q == IDLE) begin
        acc   <= '0;
        count <= '0;
      end else if (lfsr_step) begin
        acc   <= acc + {{CNT_W{1'b0}}, lfsr_next[31:20]};
        count <= count + CNT_W'(1);
      end
      if (sample_done) noise_q <= noise_sat;
    end
  end

  assign bus.noise_x     = noise_q;
  assign bus.noise_valid = valid_q;
  assign bus.busy        = (state_q == ACCUM) || (state_q == SCALE);

  a_lfsr_nonzero: assert property (@(posedge clk) disable iff (rst)
    (lfsr_state != 32'h0) && (lfsr_next != 32'h0));
endmodule

// File: tb/tb_hopf_noise_source.sv
// tb/tb_hopf_noise_source.sv - directed self-checking bench for hopf_noise_source
module tb_hopf_noise_source;
  import hopf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               clk_en;
  logic               seed_load;
  logic [31:0]        seed_in;
  logic signed [17:0] gain;
  logic signed [11:0] gain_s;

  hopf_noise_source_if #(.WIDTH(18)) bus_a ();
  hopf_noise_source_if #(.WIDTH(12)) bus_b ();

  assign bus_a.clk_en     = clk_en;
  assign bus_a.seed_load  = seed_load;
  assign bus_a.seed_in    = seed_in;
  assign bus_a.noise_gain = gain;
  assign bus_b.clk_en     = clk_en;
  assign bus_b.seed_load  = seed_load;
  assign bus_b.seed_in    = seed_in;
  assign bus_b.noise_gain = gain_s;

  hopf_noise_source #(.WIDTH(18), .FRAC(14), .SUM_N(4), .SEED(32'hACE12468)) dut (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  hopf_noise_source #(.WIDTH(12), .FRAC(8), .SUM_N(4), .SEED(32'hACE12468)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int                 pulses_a, pulses_b, first_a;
  logic signed [17:0] xa;
  logic signed [11:0] xb;
  logic               busy_h [0:12];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_in   = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // Requests one sample, then watches cycles T+1..T+12, optionally
  // pulsing clk_en or seed_load in a chosen cycle.
  task automatic run_sample(input int en_at, input int load_at);
    clk_en = 1'b1;
    tick();
    clk_en   = 1'b0;
    pulses_a = 0;
    pulses_b = 0;
    first_a  = -1;
    for (int i = 1; i <= 12; i++) begin
      busy_h[i] = bus_a.busy;
      if (bus_a.noise_valid) begin
        pulses_a++;
        if (first_a < 0) first_a = i;
        xa = bus_a.noise_x;
      end
      if (bus_b.noise_valid) begin
        pulses_b++;
        xb = bus_b.noise_x;
      end
      clk_en    = (i == en_at);
      seed_load = (i == load_at);
      tick();
    end
    clk_en    = 1'b0;
    seed_load = 1'b0;
  endtask

  initial begin
    int stray;
    rst = 1'b1; clk_en = 1'b1; seed_load = 1'b0; seed_in = 32'h0;
    gain = 18'sd16384; gain_s = 12'sd2047;
    tick(); tick();
    check("rst_noise_x", bus_a.noise_x, 0);
    check("rst_valid", bus_a.noise_valid, 0);
    check("rst_busy", bus_a.busy, 0);
    rst = 1'b0; clk_en = 1'b0;
    tick();

    run_sample(0, 0);
    check("seed_default_x", xa, -3551);
    check("seed_default_pulses", pulses_a, 1);
    check("seed_default_sat_x", xb, -2048);

    load_seed(32'h1);
    gain = ONE;
    run_sample(0, 0);
    check("seed1_x", xa, 1288);
    check("seed1_pulses", pulses_a, 1);
    check("seed1_latency", first_a, 6);
    check("seed1_busy_t1", busy_h[1], 1);
    check("seed1_busy_t5", busy_h[5], 1);
    check("seed1_busy_t6", busy_h[6], 0);
    check("sat_pos_x", xb, 2047);
    check("sat_pos_pulses", pulses_b, 1);

    load_seed(32'h1); gain = -18'sd16384;
    run_sample(0, 0);
    check("gain_neg_x", xa, -1288);
    load_seed(32'h1); gain = 18'sd32768;
    run_sample(0, 0);
    check("gain_two_x", xa, 2576);
    load_seed(32'h1); gain = 18'sd0;
    run_sample(0, 0);
    check("gain_zero_x", xa, 0);
    check("gain_zero_pulses", pulses_a, 1);

    load_seed(32'h1); gain = ONE;
    run_sample(2, 0);
    check("busy_en_pulses", pulses_a, 1);
    check("busy_en_x", xa, 1288);
    run_sample(0, 0);
    check("next4_x", xa, 3417);

    seed_in = 32'h0;
    run_sample(0, 3);
    check("abort_pulses", pulses_a, 0);
    check("abort_busy_t3", busy_h[3], 1);
    check("abort_busy_t4", busy_h[4], 0);
    check("abort_hold_x", bus_a.noise_x, 3417);
    load_seed(32'h0);
    run_sample(0, 0);
    check("zero_seed_x", xa, -3551);

    load_seed(32'h10);
    run_sample(0, 0);
    check("min_sum_x", xa, -8192);
    check("sat_neg_x", xb, -2048);

    seed_in = 32'h1; seed_load = 1'b1; clk_en = 1'b1;
    tick();
    seed_load = 1'b0; clk_en = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_a.noise_valid || bus_a.busy || bus_b.noise_valid) stray++;
      tick();
    end
    check("load_en_dropped", stray, 0);
    run_sample(0, 0);
    check("load_en_seeded_x", xa, 1288);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hopf_noise_source.md
Name: hopf_noise_source

Overview:
- Generates the `noise_x` stochastic perturbation consumed by the stochastic Hopf oscillator. It sits directly upstream of that oscillator and shares its `clk_en` update strobe.
- Produces approximately Gaussian noise by summing SUM_N uniform samples from a 32-bit Galois LFSR (Irwin-Hall/CLT). The sum is centred, scaled by a run-time gain in Q4.14, saturated, and registered.
- With `noise_gain` = 0 the output is exactly 0, so the oscillator runs deterministically.

Parameters:
- WIDTH, 18, output/gain word width (signed).
- FRAC, 14, fractional bits of `noise_gain` and the centred sum.
- SUM_N, 4, uniform samples per output; must be a power of 2, 2..16.
- SEED, 32'hACE12468, reset/fallback LFSR state; must be non-zero.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- clk_en  in  1  sample-request strobe (same strobe as oscillator update).
- seed_load  in  1  load `seed_in` into LFSR, abort any in-progress sample.
- seed_in  in  32  seed value; 0 means use SEED.
- noise_gain  in  WIDTH  signed Q4.14 gain, sampled in the SCALE state.
- noise_x  out  WIDTH  signed noise sample, registered and held between updates.
- noise_valid  out  1  one-cycle pulse when `noise_x` updates.
- busy  out  1  high in ACCUM and SCALE.

Behaviour:
- Reset (sync, on `rst`=1 at a clk edge):
  - lfsr=SEED, acc=0, state=IDLE.
  - noise_x=0, noise_valid=0, busy=0.
  - `rst` overrides all other inputs.
- LFSR: Galois right-shift, mask 32'h80200003.
  - lfsr_next = (lfsr>>1) ^ (lfsr[0] ? mask : 0).
  - The LFSR advances only in ACCUM, one step per cycle.
  - It never holds 0.
- Sample source: u = lfsr_next[31:20], 12-bit unsigned, i.e. taken from the new state.
- acc width: 12+log2(SUM_N) bits, unsigned.
- FSM transitions:
  - IDLE: on clk_en=1, go to ACCUM with acc=0 and count=0.
  - ACCUM: acc += u, lfsr <= lfsr_next, count++. After SUM_N cycles go to SCALE.
  - SCALE: c = acc − SUM_N*2048 (signed, treated as Q.FRAC). p = (c*noise_gain) >>> FRAC, arithmetic shift.
    - Saturate p to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
    - Register noise_x <= p and noise_valid <= 1; return to IDLE.
- Latency: clk_en sampled at edge T gives new noise_x and noise_valid=1 during cycle T+SUM_N+2. noise_valid is high for exactly one cycle.
- busy=1 from T+1 through the SCALE cycle.
- clk_en while busy: ignored (dropped, not queued). noise_x is unaffected.
- The oscillator samples `noise_x` on its own clk_en, so it uses the previous sample. This one-update lag is intended.
- seed_load=1, in any state:
  - lfsr <= (seed_in==0 ? SEED : seed_in), acc=0, state=IDLE.
  - noise_x holds; noise_valid=0 in the following cycle.
- seed_load and clk_en in the same cycle: seed_load wins and clk_en is dropped.
- Gain of 0 gives noise_x=0 exactly. Negative gain is legal and inverts the sample.
- The multiply is full precision (signed (acc width+1) × WIDTH); truncate only after the shift.

Decomposition:
- Shared package (`hopf_pkg`) holds:
  - LFSR mask 32'h80200003 and the default SEED constant;
  - FSM state encoding (IDLE/ACCUM/SCALE);
  - the Q-format constant ONE = 1<<FRAC.
- One natural sub-module: `noise_lfsr32`, a 32-bit Galois LFSR with step enable, load, and zero-seed guard, exposing state and next-state.
- Scaling and saturation stay inline.

Test Plan:
1. Reset: assert rst 2 cycles → noise_x=0, noise_valid=0, busy=0. First clk_en after reset yields the value predicted by a software model seeded with 32'hACE12468.
2. Known seed: seed_load with seed_in=1, gain=16384 (1.0), one clk_en.
   - LFSR sequence must be 80200003, C0300002, 60180001, B02C0003, giving u = 2050, 3075, 1537, 2818 and sum 9480.
   - Expect noise_x=1288 at T+6 with one noise_valid pulse.
3. Same seed, gain=−16384 → noise_x=−1288. With gain=32768 → 2576. With gain=0 → 0.
4. clk_en re-asserted at T+2 (during busy): it is ignored, only one noise_valid pulse appears, and LFSR advances exactly 4 steps.
5. seed_load=1 at T+3 mid-ACCUM: busy drops the next cycle, noise_valid never pulses, and noise_x holds its prior value. Then seed_in=0 plus clk_en gives the output of the SEED-seeded sequence.
6. Saturation (WIDTH=12 build, gain=2047, seed forcing large |c|): noise_x clamps to 2047 or −2048, never wraps. Combined seed_load+clk_en in the same cycle → no sample is produced.
